// File: rtl/pwm_peripheral.sv
// Shared-counter 16-output PWM stage. Duty is shadowed at each period wrap,
// while the enable selects take effect on the next clock.
module pwm_peripheral #(
  parameter int CLK_DIV = 3000,
  parameter int PS_W    = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  en_reg_out_7_0_i,
  input  logic [7:0]  en_reg_out_15_8_i,
  input  logic [7:0]  en_reg_pwm_7_0_i,
  input  logic [7:0]  en_reg_pwm_15_8_i,
  input  logic [7:0]  pwm_duty_cycle_i,
  output logic [15:0] out_o,
  output logic        period_start_o,
  output logic [7:0]  duty_active_o
);
  localparam int NUM_LANES = 16;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV - 1);

  logic [PS_W-1:0]      ps_q, ps_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           duty_q, duty_d;
  logic                 pstart_q;
  logic [NUM_LANES-1:0] out_q, out_d;
  logic [NUM_LANES-1:0] en_out, en_pwm;
  logic                 tick, wrap, pwm_raw;

  assign en_out = {en_reg_out_15_8_i, en_reg_out_7_0_i};
  assign en_pwm = {en_reg_pwm_15_8_i, en_reg_pwm_7_0_i};

  always_comb begin
    tick    = (ps_q == PS_MAX);
    wrap    = tick && (cnt_q == 8'hFF);
    ps_d    = tick ? '0 : ps_q + PS_W'(1);
    cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
    duty_d  = wrap ? pwm_duty_cycle_i : duty_q;
    // 0xFF maps to full-on rather than 255/256 so 100% is reachable.
    pwm_raw = (duty_q == 8'hFF) || (cnt_q < duty_q);
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign out_d[i] = en_out[i] & (en_pwm[i] ? pwm_raw : 1'b1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ps_q     <= '0;
      cnt_q    <= '0;
      duty_q   <= '0;
      pstart_q <= 1'b0;
      out_q    <= '0;
    end else begin
      ps_q     <= ps_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      pstart_q <= wrap;
      out_q    <= out_d;
    end
  end

  assign out_o          = out_q;
  assign period_start_o = pstart_q;
  assign duty_active_o  = duty_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomized scoreboard bench: two DUTs (CLK_DIV=4 and CLK_DIV=1) share stimulus
// and are compared each clock against an arithmetic reference model.
module tb_pwm_peripheral;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [7:0]  eo_lo = '0, eo_hi = '0, ep_lo = '0, ep_hi = '0, duty = '0;
  logic [15:0] out4, out1;
  logic        ps4, ps1;
  logic [7:0]  da4, da1;

  pwm_peripheral #(.CLK_DIV(4), .PS_W(12)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .en_reg_out_7_0_i(eo_lo), .en_reg_out_15_8_i(eo_hi),
    .en_reg_pwm_7_0_i(ep_lo), .en_reg_pwm_15_8_i(ep_hi),
    .pwm_duty_cycle_i(duty),
    .out_o(out4), .period_start_o(ps4), .duty_active_o(da4));

  pwm_peripheral #(.CLK_DIV(1), .PS_W(12)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .en_reg_out_7_0_i(eo_lo), .en_reg_out_15_8_i(eo_hi),
    .en_reg_pwm_7_0_i(ep_lo), .en_reg_pwm_15_8_i(ep_hi),
    .pwm_duty_cycle_i(duty),
    .out_o(out1), .period_start_o(ps1), .duty_active_o(da1));

  typedef struct packed {
    logic [15:0] o;
    logic        ps;
    logic [7:0]  da;
  } exp_t;

  exp_t       q0[$], q1[$];
  int         n_m[2];          // clocks counted since reset release
  logic [7:0] sh_m[2];         // duty in effect
  int         vectors = 0, errs = 0;
  logic [15:0] g_eo = '0, g_ep = '0;
  logic [7:0]  g_dc = '0;

  // Model: the tick index is clocks/div, the counter is that mod 256, and a
  // period ends on the last clock of tick 255.
  task automatic step(input logic r);
    exp_t e;
    int   dv, cnt;
    bit   tk, w, raw;
    @(negedge clk);
    rst = r; {eo_hi, eo_lo} = g_eo; {ep_hi, ep_lo} = g_ep; duty = g_dc;
    for (int d = 0; d < 2; d++) begin
      dv = (d == 0) ? 4 : 1;
      e  = '0;
      if (r) begin
        n_m[d] = 0; sh_m[d] = 8'h00;
      end else begin
        cnt = (n_m[d] / dv) % 256;
        tk  = (n_m[d] % dv) == dv - 1;
        w   = tk && (cnt == 255);
        raw = (sh_m[d] == 8'hFF) || (cnt < int'(sh_m[d]));
        for (int i = 0; i < 16; i++) e.o[i] = g_eo[i] && (g_ep[i] ? raw : 1'b1);
        if (w) sh_m[d] = g_dc;
        e.ps = w;
        e.da = sh_m[d];
        n_m[d]++;
      end
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic run(input int k);
    for (int j = 0; j < k; j++) step(1'b0);
  endtask

  task automatic check(input int d, input exp_t e, input exp_t a);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL dut_div%0d t=%0t: got out=%h ps=%b da=%h, want out=%h ps=%b da=%h",
               (d == 0) ? 4 : 1, $time, a.o, a.ps, a.da, e.o, e.ps, e.da);
    end
  endtask

  // Monitor: the DUTs present an output every clock, so pop one entry per edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) check(0, q0.pop_front(), {out4, ps4, da4});
      if (q1.size() > 0) check(1, q1.pop_front(), {out1, ps1, da1});
    end
  end

  initial begin
    int guard;
    // Reset with every input at 0xFF.
    g_eo = 16'hFFFF; g_ep = 16'hFFFF; g_dc = 8'hFF;
    repeat (3) step(1'b1);
    // Static drive, then drop one enable.
    g_eo = 16'h00FF; g_ep = 16'h0000; g_dc = 8'h80;
    run(20);
    g_eo = 16'h00F7;
    run(1010);
    // 50% on all lanes across several periods.
    g_eo = 16'hFFFF; g_ep = 16'hFFFF;
    run(3072);
    // Extremes.
    g_dc = 8'h00; run(2048);
    g_dc = 8'hFF; run(2048);
    // Mid-period change: move to 0xC0 partway into a 0x40 period.
    g_dc = 8'h40;
    guard = 0;
    while (!(((n_m[0] / 4) % 256) == 32'h20 && sh_m[0] == 8'h40) && guard < 3000) begin
      step(1'b0); guard++;
    end
    g_dc = 8'hC0;
    run(2100);
    // Reset mid-period with 0x80 in effect.
    g_dc = 8'h80;
    guard = 0;
    while (!(((n_m[0] / 4) % 256) == 32'h50 && sh_m[0] == 8'h80) && guard < 3000) begin
      step(1'b0); guard++;
    end
    step(1'b1);
    run(1100);
    // Random enables, occasional duty changes and resets.
    for (int j = 0; j < 4000; j++) begin
      if ($urandom_range(15) == 0) begin
        g_eo = 16'($urandom); g_ep = 16'($urandom);
      end
      if ($urandom_range(199) == 0) begin
        case ($urandom_range(3))
          0: g_dc = 8'h00;
          1: g_dc = 8'hFF;
          default: g_dc = 8'($urandom);
        endcase
      end
      step($urandom_range(1499) == 0);
    end
    repeat (3) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
